// File: rtl/gnr_pkg.sv
// gnr_pkg: shared types and constants for the GNR network cycle controller.
//   gnr_state_t  controller states (IDLE, LOAD, DETECT, PERIOD, DONE)
//   GNR_CNT_W    default width of the step and period counters
//   LOAD_CYCLES  number of cycles reset_nos is held while the node cells load
package gnr_pkg;

    localparam int GNR_CNT_W   = 32;
    localparam int LOAD_CYCLES = 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DETECT,
        PERIOD,
        DONE
    } gnr_state_t;

endpackage

// File: rtl/gnr_vec_cmp.sv
// gnr_vec_cmp: state-vector equality with a step-count qualifier.
//   a, b      N_NODES  vectors to compare (tortoise / hare)
//   cnt       CNT_W    current step count
//   even_req  1        when set, cnt must be even to qualify
//   min_cnt   CNT_W    cnt must be at least this value to qualify
//   match     1        a==b and both count qualifiers hold
module gnr_vec_cmp
    import gnr_pkg::*;
#(
    parameter int N_NODES = 22,
    parameter int CNT_W   = GNR_CNT_W
) (
    input  logic [N_NODES-1:0] a,
    input  logic [N_NODES-1:0] b,
    input  logic [CNT_W-1:0]   cnt,
    input  logic               even_req,
    input  logic [CNT_W-1:0]   min_cnt,
    output logic               match
);

    logic even_ok;
    logic min_ok;

    assign even_ok = !even_req || !cnt[0];
    assign min_ok  = (cnt >= min_cnt);
    assign match   = (a == b) && even_ok && min_ok;

endmodule

// File: rtl/gnr_cycle_ctrl.sv
// gnr_cycle_ctrl: drives the GNR node cells through Floyd cycle detection,
// then measures the attractor period.
//   clk, rst        clock, asynchronous active-high reset
//   start           run request, honoured only in IDLE or DONE
//   init_vec        initial network state, captured on the start cycle
//   s0_vec, s1_vec  tortoise / hare state vectors from the nodes
//   reset_nos       node load pulse; init_state is the per-node load value
//   start_s0/s1     tortoise / hare advance strobes
//   busy, done      run in progress / results valid (held until next start)
//   detect_steps    hare steps at first s0==s1 match
//   period          attractor cycle length
//   attractor       s0_vec captured at detection
//   timeout         run aborted on step limit
// Optional build macro GNR_TIMEOUT_EN adds the MAX_STEPS limit; without it
// counters wrap silently and timeout is tied 0.
//
// state  | meaning
// IDLE   | waiting for start after reset
// LOAD   | reset_nos asserted, node cells load init_state
// DETECT | hare and tortoise stepping until s0==s1 on an even hare count
// PERIOD | tortoise frozen, hare stepping until it returns to s0
// DONE   | results valid, waiting for the next start
module gnr_cycle_ctrl
    import gnr_pkg::*;
#(
    parameter int               N_NODES   = 22,
    parameter int               CNT_W     = GNR_CNT_W,
    parameter logic [CNT_W-1:0] MAX_STEPS = {CNT_W{1'b1}}
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N_NODES-1:0] init_vec,
    input  logic [N_NODES-1:0] s0_vec,
    input  logic [N_NODES-1:0] s1_vec,
    output logic               reset_nos,
    output logic [N_NODES-1:0] init_state,
    output logic               start_s0,
    output logic               start_s1,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   detect_steps,
    output logic [CNT_W-1:0]   period,
    output logic [N_NODES-1:0] attractor,
    output logic               timeout
);

    gnr_state_t       state;
    gnr_state_t       state_nxt;
    logic [CNT_W-1:0] hare_cnt;
    logic [CNT_W-1:0] per_cnt;
    logic [1:0]       ld_cnt;
    logic             in_detect;
    logic             in_period;
    logic             match;
    logic             hit;
    logic             phit;
    logic             det_lim;
    logic             per_lim;
    logic             go;

    assign in_detect = (state == DETECT);
    assign in_period = (state == PERIOD);
    assign go        = start && ((state == IDLE) || (state == DONE));

    // One comparator serves both phases: DETECT needs an even hare count of
    // at least 2 (tortoise has then taken exactly half the steps), PERIOD
    // needs the hare to have moved at least once.
    gnr_vec_cmp #(
        .N_NODES (N_NODES),
        .CNT_W   (CNT_W)
    ) u_cmp (
        .a        (s0_vec),
        .b        (s1_vec),
        .cnt      (in_detect ? hare_cnt : per_cnt),
        .even_req (in_detect),
        .min_cnt  (in_detect ? CNT_W'(2) : CNT_W'(1)),
        .match    (match)
    );

    assign hit  = in_detect && match;
    assign phit = in_period && match;

`ifdef GNR_TIMEOUT_EN
    assign det_lim = (hare_cnt == MAX_STEPS);
    assign per_lim = (per_cnt == MAX_STEPS);
`else
    logic unused_max;
    assign unused_max = ^MAX_STEPS;
    assign det_lim    = 1'b0;
    assign per_lim    = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (go) state_nxt = LOAD;
            LOAD:       if (ld_cnt == 2'd0) state_nxt = DETECT;
            DETECT: begin
                if (hit)          state_nxt = PERIOD;
                else if (det_lim) state_nxt = DONE;
            end
            PERIOD:     if (phit || per_lim) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        reset_nos = (state == LOAD);
        busy      = (state == LOAD) || in_detect || in_period;
        done      = (state == DONE);
        start_s0  = in_detect && !hit;
        start_s1  = (in_detect && !hit) || (in_period && !phit);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_state   <= '0;
            hare_cnt     <= '0;
            per_cnt      <= '0;
            ld_cnt       <= '0;
            detect_steps <= '0;
            period       <= '0;
            attractor    <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (go) begin
                        init_state <= init_vec;
                        hare_cnt   <= '0;
                        per_cnt    <= '0;
                        ld_cnt     <= 2'(LOAD_CYCLES - 1);
                    end
                end
                LOAD: begin
                    if (ld_cnt != 2'd0) ld_cnt <= ld_cnt - 2'd1;
                end
                DETECT: begin
                    if (hit) begin
                        detect_steps <= hare_cnt;
                        attractor    <= s0_vec;
                    end else begin
                        hare_cnt <= hare_cnt + CNT_W'(1);
                        if (det_lim) begin
                            detect_steps <= MAX_STEPS;
                            period       <= '0;
                        end
                    end
                end
                PERIOD: begin
                    if (phit) begin
                        period <= per_cnt;
                    end else begin
                        per_cnt <= per_cnt + CNT_W'(1);
                        if (per_lim) period <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef GNR_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout <= 1'b0;
        end else if (go) begin
            timeout <= 1'b0;
        end else if ((in_detect && !hit && det_lim) || (in_period && !phit && per_lim)) begin
            timeout <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_gnr_cycle_ctrl.sv
module tb_gnr_cycle_ctrl;

    localparam int N = 22;
    localparam int W = 32;
`ifdef GNR_TIMEOUT_EN
    localparam logic [W-1:0] TB_MAX = 32'd8;
`else
    localparam logic [W-1:0] TB_MAX = 32'hFFFF_FFFF;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [N-1:0] init_vec = '0;
    logic [N-1:0] s0_vec = '0;
    logic [N-1:0] s1_vec = '0;
    logic         reset_nos;
    logic [N-1:0] init_state;
    logic         start_s0;
    logic         start_s1;
    logic         busy;
    logic         done;
    logic [W-1:0] detect_steps;
    logic [W-1:0] period;
    logic [N-1:0] attractor;
    logic         timeout;

    // node model: 0 identity, 1 toggle, 2 3-bit one-hot ring,
    // 3 chain 0..11 (transient 5, then cycle 5..11 of length 7)
    logic [1:0]   mode = 2'd0;
    logic         ph = 1'b0;

    int checks = 0;
    int failures = 0;

    gnr_cycle_ctrl #(
        .N_NODES   (N),
        .CNT_W     (W),
        .MAX_STEPS (TB_MAX)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .init_vec     (init_vec),
        .s0_vec       (s0_vec),
        .s1_vec       (s1_vec),
        .reset_nos    (reset_nos),
        .init_state   (init_state),
        .start_s0     (start_s0),
        .start_s1     (start_s1),
        .busy         (busy),
        .done         (done),
        .detect_steps (detect_steps),
        .period       (period),
        .attractor    (attractor),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] nf(input logic [1:0] m, input logic [N-1:0] v);
        case (m)
            2'd0:    nf = v;
            2'd1:    nf = ~v;
            2'd2:    nf = {v[N-1:3], v[1:0], v[2]};
            default: nf = (v == 22'd11) ? 22'd5 : v + 22'd1;
        endcase
    endfunction

    // node cells: s0 advances on the 1st, 3rd, 5th... strobe after load
    always @(posedge clk) begin
        if (reset_nos) begin
            s0_vec <= init_state;
            s1_vec <= init_state;
            ph     <= 1'b0;
        end else begin
            if (start_s1) s1_vec <= nf(mode, s1_vec);
            if (start_s0) begin
                if (!ph) s0_vec <= nf(mode, s0_vec);
                ph <= ~ph;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start(input logic [N-1:0] iv);
        @(negedge clk);
        init_vec = iv;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    // n counts clock edges from the start edge up to the one that makes done visible
    task automatic wait_done(input string tag, output int n);
        n = 1;
        while (!done && n < 500) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, 64'(done), 64'd1);
    endtask

    task automatic run_case(input string tag, input logic [1:0] m, input logic [N-1:0] iv,
                            input int exp_det, input int exp_per, input logic [N-1:0] exp_att);
        int n;
        mode = m;
        pulse_start(iv);
        wait_done(tag, n);
        check({tag, "_det"}, 64'(detect_steps), 64'(exp_det));
        check({tag, "_per"}, 64'(period), 64'(exp_per));
        check({tag, "_att"}, 64'(attractor), 64'(exp_att));
        check({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_strobes", 64'({reset_nos, start_s0, start_s1}), 64'd0);
        check("rst_det", 64'(detect_steps), 64'd0);
        check("rst_per", 64'(period), 64'd0);
        check("rst_att", 64'(attractor), 64'd0);
        check("rst_init", 64'(init_state), 64'd0);
        check("rst_tmo", 64'(timeout), 64'd0);
        rst = 1'b0;

        // identity: LOAD, DETECT hc0/hc1 strobes, hit at hc2, PERIOD pc0 strobe,
        // phit at pc1, DONE -> done visible 7 edges from the start edge
        mode = 2'd0;
        pulse_start(22'h15A5A5);
        check("id_load_rn", 64'(reset_nos), 64'd1);
        check("id_load_busy", 64'(busy), 64'd1);
        check("id_load_strb", 64'({start_s0, start_s1}), 64'd0);
        check("id_init", 64'(init_state), 64'h15A5A5);
        wait_done("id", n);
        check("id_lat", 64'(n), 64'd7);
        check("id_det", 64'(detect_steps), 64'd2);
        check("id_per", 64'(period), 64'd1);
        check("id_att", 64'(attractor), 64'h15A5A5);
        check("id_tmo", 64'(timeout), 64'd0);

        run_case("tog", 2'd1, 22'h0, 4, 2, 22'h0);

        // ring, with a start pulse during PERIOD that must be ignored
        mode = 2'd2;
        pulse_start(22'h1);
        n = 0;
        while (!(busy && start_s1 && !start_s0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("ring_in_period", 64'(busy && start_s1 && !start_s0), 64'd1);
        init_vec = 22'h3FFFFF;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        check("ring_ign_busy", 64'(busy), 64'd1);
        wait_done("ring", n);
        check("ring_det", 64'(detect_steps), 64'd6);
        check("ring_per", 64'(period), 64'd3);
        check("ring_att", 64'(attractor), 64'h1);
        check("ring_init_kept", 64'(init_state), 64'h1);

        // start in DONE restarts and clears done on the next cycle
        mode     = 2'd0;
        init_vec = 22'h15A5A5;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        check("rs_done", 64'(done), 64'd0);
        check("rs_busy", 64'(busy), 64'd1);
        check("rs_rn", 64'(reset_nos), 64'd1);
        wait_done("rs", n);
        check("rs_det", 64'(detect_steps), 64'd2);
        check("rs_per", 64'(period), 64'd1);

        // reset in DETECT at hare_cnt=3 (ring has no hit there)
        mode = 2'd2;
        pulse_start(22'h1);
        repeat (4) @(negedge clk);
        check("ab_strobe", 64'({busy, start_s1}), 64'd3);
        rst = 1'b1;
        @(negedge clk);
        check("ab_busy", 64'(busy), 64'd0);
        check("ab_done", 64'(done), 64'd0);
        check("ab_strobes", 64'({reset_nos, start_s0, start_s1}), 64'd0);
        check("ab_det", 64'(detect_steps), 64'd0);
        check("ab_per", 64'(period), 64'd0);
        check("ab_att", 64'(attractor), 64'd0);
        check("ab_init", 64'(init_state), 64'd0);
        rst = 1'b0;

        run_case("id2", 2'd0, 22'h15A5A5, 2, 1, 22'h15A5A5);

`ifdef GNR_TIMEOUT_EN
        // chain: hare k vs tortoise k/2 never equal for k<=8, limit hits at hare_cnt=8
        mode = 2'd3;
        pulse_start(22'h0);
        wait_done("tmo", n);
        check("tmo_flag", 64'(timeout), 64'd1);
        check("tmo_det", 64'(detect_steps), 64'd8);
        check("tmo_per", 64'(period), 64'd0);
`else
        run_case("chain", 2'd3, 22'h0, 14, 7, 22'd7);
        check("chain_tmo", 64'(timeout), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
